// File: rtl/password_candidate_gen.sv
// Brute-force candidate generator: odometer over the 36-symbol alphabet 0-9,A-Z
// with the leftmost character limited to a programmable index range.
module password_candidate_gen #(
    parameter int NCHARS = 4,
    parameter int CNT_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [5:0]          from,
    input  logic [5:0]          to,
    input  logic                stop,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [8*NCHARS-1:0] candidate,
    output logic [CNT_W-1:0]    cand_count,
    output logic                busy,
    output logic                done,
    output logic                exhausted,
    output logic                range_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;
    localparam logic [5:0] LAST_IDX = 6'd35;

    function automatic logic [7:0] ascii_of(input logic [5:0] idx);
        logic [7:0] c;
        if (idx < 6'd10) begin
            c = 8'h30 + {2'b00, idx};
        end else begin
            c = 8'h37 + {2'b00, idx};
        end
        return c;
    endfunction

    // Digit 0 (leftmost) lands in the top byte, matching string-literal packing.
    function automatic logic [8*NCHARS-1:0] decode(input logic [NCHARS-1:0][5:0] d);
        logic [8*NCHARS-1:0] s;
        s = '0;
        for (int i = 0; i < NCHARS; i++) begin
            s[8*(NCHARS-1-i) +: 8] = ascii_of(d[i]);
        end
        return s;
    endfunction

    logic [1:0]              state_r, state_nx_s;
    logic [NCHARS-1:0][5:0]  digits_r, digits_nx_s, digits_inc_s;
    logic [5:0]              to_r, to_nx_s;
    logic                    cand_valid_r, cand_valid_nx_s;
    logic                    busy_r, busy_nx_s;
    logic                    done_r, done_nx_s;
    logic                    exhausted_r, exhausted_nx_s;
    logic                    range_err_r, range_err_nx_s;
    logic [CNT_W-1:0]        cand_count_r, cand_count_nx_s;
    logic [8*NCHARS-1:0]     candidate_r;
    logic                    last_s;
    logic                    xfer_s;
    logic                    range_ok_s;

    assign xfer_s     = cand_valid_r & cand_ready;
    assign range_ok_s = (from <= to) && (to <= LAST_IDX);

    // Odometer increment (rightmost digit first) and last-candidate detection.
    always_comb begin
        logic carry_s;
        digits_inc_s = digits_r;
        carry_s      = 1'b1;
        for (int i = NCHARS - 1; i >= 0; i--) begin
            if (carry_s) begin
                if (digits_r[i] == LAST_IDX) begin
                    digits_inc_s[i] = 6'd0;
                end else begin
                    digits_inc_s[i] = digits_r[i] + 6'd1;
                    carry_s         = 1'b0;
                end
            end else begin
                digits_inc_s[i] = digits_r[i];
            end
        end
        last_s = (digits_r[0] == to_r);
        for (int i = 1; i < NCHARS; i++) begin
            last_s = last_s & (digits_r[i] == LAST_IDX);
        end
    end

    // Sweep control: next values for every registered output.
    always_comb begin
        state_nx_s      = state_r;
        digits_nx_s     = digits_r;
        to_nx_s         = to_r;
        cand_valid_nx_s = cand_valid_r;
        busy_nx_s       = busy_r;
        done_nx_s       = 1'b0;
        exhausted_nx_s  = exhausted_r;
        range_err_nx_s  = range_err_r;
        cand_count_nx_s = cand_count_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cand_count_nx_s = '0;
                    exhausted_nx_s  = 1'b0;
                    if (range_ok_s) begin
                        to_nx_s         = to;
                        digits_nx_s     = '0;
                        digits_nx_s[0]  = from;
                        range_err_nx_s  = 1'b0;
                        cand_valid_nx_s = 1'b1;
                        busy_nx_s       = 1'b1;
                        state_nx_s      = ST_RUN;
                    end else begin
                        range_err_nx_s  = 1'b1;
                        done_nx_s       = 1'b1;
                        state_nx_s      = ST_FIN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    cand_count_nx_s = (cand_count_r == {CNT_W{1'b1}}) ? cand_count_r
                                                                      : cand_count_r + 1'b1;
                end else begin
                    cand_count_nx_s = cand_count_r;
                end
                // A transfer in the same cycle as stop still counts before finishing.
                if (xfer_s && last_s) begin
                    exhausted_nx_s  = 1'b1;
                    cand_valid_nx_s = 1'b0;
                    busy_nx_s       = 1'b0;
                    done_nx_s       = 1'b1;
                    state_nx_s      = ST_FIN;
                end else if (stop) begin
                    digits_nx_s     = xfer_s ? digits_inc_s : digits_r;
                    cand_valid_nx_s = 1'b0;
                    busy_nx_s       = 1'b0;
                    done_nx_s       = 1'b1;
                    state_nx_s      = ST_FIN;
                end else begin
                    digits_nx_s = xfer_s ? digits_inc_s : digits_r;
                    state_nx_s  = ST_RUN;
                end
            end
            ST_FIN: begin
                cand_valid_nx_s = 1'b0;
                busy_nx_s       = 1'b0;
                state_nx_s      = ST_IDLE;
            end
            default: begin
                cand_valid_nx_s = 1'b0;
                busy_nx_s       = 1'b0;
                state_nx_s      = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            digits_r     <= '0;
            to_r         <= 6'd0;
            cand_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            exhausted_r  <= 1'b0;
            range_err_r  <= 1'b0;
            cand_count_r <= '0;
            candidate_r  <= '0;
        end else begin
            state_r      <= state_nx_s;
            digits_r     <= digits_nx_s;
            to_r         <= to_nx_s;
            cand_valid_r <= cand_valid_nx_s;
            busy_r       <= busy_nx_s;
            done_r       <= done_nx_s;
            exhausted_r  <= exhausted_nx_s;
            range_err_r  <= range_err_nx_s;
            cand_count_r <= cand_count_nx_s;
            if (state_nx_s == ST_RUN) begin
                candidate_r <= decode(digits_nx_s);
            end else begin
                candidate_r <= candidate_r;
            end
        end
    end

    assign cand_valid = cand_valid_r;
    assign candidate  = candidate_r;
    assign cand_count = cand_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign exhausted  = exhausted_r;
    assign range_err  = range_err_r;

endmodule

// File: doc/password_candidate_gen.md
# password_candidate_gen

Upstream candidate generator for the brute-force password cracker. On `start` it enumerates every NCHARS-character string over the 36-symbol alphabet 0-9, A-Z, with the leftmost character restricted to an index range [from, to], and streams the strings as ASCII words over a valid/ready handshake to the comparator stage. Its output format matches the cracker's `password_to_crack` packing, and an abort input lets the comparator stop the sweep as soon as it reports `found`.

## Interface
- NCHARS, 4, characters per candidate
- CNT_W, 24, width of the accepted-candidate counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- from  in  6  first alphabet index for the leftmost character, sampled on start
- to  in  6  last alphabet index for the leftmost character, sampled on start
- stop  in  1  abort the current sweep (driven by the comparator's found)
- cand_valid  out  1  candidate is valid
- cand_ready  in  1  consumer accepts the candidate
- candidate  out  8*NCHARS  ASCII string; leftmost character in the top byte (Verilog string-literal order)
- cand_count  out  CNT_W  number of candidates accepted in the current or last sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep ends for any reason
- exhausted  out  1  last sweep emitted the full range; held until next start
- range_err  out  1  last start had from>to or to>35; held until next start

## Operation
- Alphabet map: index i in 0..9 -> 8'h30+i; index i in 10..35 -> 8'h41+(i-10).
- Internal state: NCHARS 6-bit digit registers. Digit 0 is leftmost.
- Candidate is a registered decode of the digits.
- Odometer order:
  - The rightmost digit increments first, 0..35.
  - On wrap to 0 it carries into the next digit.
  - Digit 0 runs from..to.
- FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - On start with a valid range: latch from/to, set digits to {from,0,...,0}, clear cand_count, exhausted and range_err. Go to RUN.
  - On start with an invalid range: set range_err, clear exhausted and cand_count. Go to FIN. No candidate is emitted.
- RUN:
  - cand_valid=1, busy=1.
  - Transfer occurs when cand_valid && cand_ready. On a transfer, cand_count increments and the odometer advances.
  - Transfer of the last candidate {to,35,...,35} sets exhausted and goes to FIN.
  - stop=1: go to FIN, exhausted stays 0.
  - If stop and a transfer happen in the same cycle, the transfer counts (cand_count increments), then the FSM goes to FIN.
- FIN: done=1 for exactly one cycle, busy=0, cand_valid=0. Go to IDLE.
- start outside IDLE is ignored. stop outside RUN is ignored.
- cand_count saturates at all-ones. It does not wrap; 36^4=1,679,616 fits in 24 bits.

## Timing
- All outputs are registered.
- Reset (rst=0 at a clock edge) applies in any state, including mid-sweep. Values at the next edge:
  - FSM = IDLE
  - cand_valid, busy, done, exhausted, range_err = 0
  - cand_count = 0
  - candidate = 0, digits = 0
  - start is ignored while rst=0.
- start sampled at edge N -> cand_valid=1 and the first candidate visible after edge N+1 (1-cycle latency).
- With cand_ready held high, one candidate is accepted per cycle. Candidate k+1 is visible the cycle after transfer k.
- Backpressure: while cand_valid && !cand_ready, candidate and cand_valid hold stable.
- Last transfer or stop at edge M -> cand_valid=0 and done=1 after edge M+1. done=0 and IDLE after edge M+2.
- Invalid-range start at edge N -> done=1 after edge N+1. cand_valid never rises.
- Back-to-back sweeps: start is accepted in the cycle after done, i.e. once the FSM is back in IDLE.

## Test plan
- Basic sweep:
  - Stimulus: from=0, to=0, ready=1.
  - Response: sequence "0000", "0001" ... "0009", "000A" ... "000Z", "0010" ... "0ZZZ"; then done pulse, exhausted=1, cand_count=46656.
- Backpressure:
  - Stimulus: from=to=10, ready=0 for 5 cycles after the first valid, then 1.
  - Response: candidate holds "A000" for 5 cycles with cand_count=0. The next visible value is "A001".
- Abort:
  - Stimulus: from=0, to=35, ready=1, stop asserted in the cycle of the 10th transfer.
  - Response: cand_count=10, done pulse the next cycle, exhausted=0, busy=0.
- Range errors:
  - Stimulus: start with from=5, to=3; separately start with from=0, to=36.
  - Response: in each case no cand_valid, done one cycle after start, range_err=1.
- Carry and wrap:
  - Stimulus: from=to=35.
  - Response: "Z00Z" is followed by "Z010". The sweep ends on "ZZZZ" with cand_count=46656.
- Reset mid-run:
  - Stimulus: rst=0 for one cycle after 100 transfers.
  - Response: all outputs 0 at the next edge. A fresh start restarts at {from,0,0,0}.
